// File: rtl/regfile_writeback_if.sv
// Write-back request bus and register-file write port bundle.
// No timing of its own; the slave registers the rf_* side.
// in_valid/in_ready handshake on the request side; rf_* has no backpressure.
interface regfile_writeback_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [3:0]       in_addr1;
  logic [3:0]       in_addr2;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data15;

  logic [3:0]       rf_add1;
  logic [3:0]       rf_add2;
  logic [WIDTH-1:0] rf_wdata1;
  logic [WIDTH-1:0] rf_wdata2;
  logic [WIDTH-1:0] rf_wdata15;
  logic [1:0]       rf_wdst;

  // Request producer side.
  modport master (
    output in_valid, in_mode, in_addr1, in_addr2, in_data1, in_data2, in_data15,
    input  in_ready,
    input  rf_add1, rf_add2, rf_wdata1, rf_wdata2, rf_wdata15, rf_wdst
  );

  // Write-back buffer side.
  modport slave (
    input  in_valid, in_mode, in_addr1, in_addr2, in_data1, in_data2, in_data15,
    output in_ready,
    output rf_add1, rf_add2, rf_wdata1, rf_wdata2, rf_wdata15, rf_wdst
  );
endinterface

// File: rtl/regfile_writeback.sv
// Buffers register write-back requests in a DEPTH-entry FIFO and issues one per cycle to the RF.
// Latency: accepted at edge N into an empty buffer, presented on rf_* after edge N+1 for one cycle.
// in_ready = !full; hold stalls issue; flush discards everything; lookup forwards youngest pending data.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  regfile_writeback_if.slave wb,
  input  logic             flush,
  input  logic             hold,
  input  logic [3:0]       lk_addr,
  output logic             lk_hit,
  output logic [WIDTH-1:0] lk_data,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] M_A1  = 2'b00;
  localparam logic [1:0] M_A2  = 2'b01;
  localparam logic [1:0] M_R15 = 2'b10;
  localparam logic [1:0] M_NOP = 2'b11;

  typedef struct packed {
    logic [1:0]       mode;
    logic [3:0]       a1;
    logic [3:0]       a2;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d15;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  entry_t          rf_q, rf_d;    // entry on the rf_* port; mode 11 means nothing presented

  entry_t          in_entry;
  logic            push;
  logic            pop;

  assign full        = (count_q == 4'(DEPTH));
  assign empty       = (count_q == 4'd0);
  assign count       = count_q;
  assign wb.in_ready = !full;

  assign in_entry = '{mode: wb.in_mode, a1: wb.in_addr1, a2: wb.in_addr2,
                      d1: wb.in_data1, d2: wb.in_data2, d15: wb.in_data15};

  // No-op requests are acknowledged but never stored; flush drops the concurrent push.
  assign push = wb.in_valid && wb.in_ready && (wb.in_mode != M_NOP) && !flush;
  assign pop  = !empty && !hold && !flush;

  assign wb.rf_wdst    = rf_q.mode;
  assign wb.rf_add1    = rf_q.a1;
  assign wb.rf_add2    = rf_q.a2;
  assign wb.rf_wdata1  = rf_q.d1;
  assign wb.rf_wdata2  = rf_q.d2;
  assign wb.rf_wdata15 = rf_q.d15;

  // Next-state for pointers, occupancy and the presented entry; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rf_d     = rf_q;
    rf_d.mode = M_NOP;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rf_d     = mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset clears the buffer and the presented entry without issuing anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      rf_q     <= '{mode: M_NOP, default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rf_q     <= rf_d;
    end
  end

  // Storage array; validity is tracked by the pointers so contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // Per-entry match: addr2 overrides addr1, R15 overrides addr1 when both name the same register.
  function automatic logic [WIDTH:0] entry_match(entry_t e, logic [3:0] a);
    logic             hit;
    logic [WIDTH-1:0] d;
    hit = 1'b0;
    d   = '0;
    if (e.mode != M_NOP && e.a1 == a) begin
      hit = 1'b1;
      d   = e.d1;
    end
    if (e.mode == M_A2 && e.a2 == a) begin
      hit = 1'b1;
      d   = e.d2;
    end
    if (e.mode == M_R15 && a == 4'd15) begin
      hit = 1'b1;
      d   = e.d15;
    end
    return {hit, d};
  endfunction

  logic [WIDTH:0] lk_r;

  // Forwarding lookup scanned oldest to youngest (presented entry first) so the youngest match wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_r    = entry_match(rf_q, lk_addr);
    if (lk_r[WIDTH]) begin
      lk_hit  = 1'b1;
      lk_data = lk_r[WIDTH-1:0];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) begin
        lk_r = entry_match(mem_q[rd_ptr_q + AW'(i)], lk_addr);
        if (lk_r[WIDTH]) begin
          lk_hit  = 1'b1;
          lk_data = lk_r[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered write-back requests (power of two, 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the data width of every data port.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  write-back request present.
REQ-006 The block SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 The block SHALL have port in_mode  input  2  write mode: 00 = addr1 only; 01 = addr1 and addr2; 10 = addr1 and R15; 11 = no-op (accepted, discarded).
REQ-008 The block SHALL have ports in_addr1 and in_addr2  input  4 each  destination register addresses.
REQ-009 The block SHALL have ports in_data1, in_data2 and in_data15  input  WIDTH each  write data for addr1, addr2 and R15.
REQ-010 The block SHALL have port flush  input  1  synchronous discard of all buffered requests.
REQ-011 The block SHALL have port hold  input  1  register file busy; suppresses issue.
REQ-012 The block SHALL have ports rf_add1 and rf_add2  output  4 each  register file write addresses.
REQ-013 The block SHALL have ports rf_wdata1, rf_wdata2 and rf_wdata15  output  WIDTH each  register file write data.
REQ-014 The block SHALL have port rf_wdst  output  2  register file write-destination code; same encoding as in_mode, with 11 = no write.
REQ-015 The block SHALL have port lk_addr  input  4  forwarding lookup address.
REQ-016 The block SHALL have ports lk_hit  output  1  and lk_data  output  WIDTH: pending write to lk_addr exists, and its youngest data.
REQ-017 The block SHALL have ports count  output  4  number of buffered entries; full  output  1; empty  output  1.

Function
REQ-018 The block SHALL buffer requests in a DEPTH-entry FIFO; in_ready = !full; a push while full SHALL NOT occur, even if a pop happens in the same cycle.
REQ-019 Mode-11 requests SHALL be acknowledged and SHALL NOT occupy an entry.
REQ-020 Each cycle with !empty, !hold and !flush, the block SHALL pop the head entry and present it on the rf_* outputs, registered, for exactly one cycle; otherwise rf_wdst SHALL be 11 and the other rf_* outputs SHALL hold their previous values.
REQ-021 Latency SHALL be: a request accepted at edge N into an empty FIFO with hold low appears on rf_* after edge N+1 (one cycle of visibility).
REQ-022 A simultaneous push and pop SHALL leave count unchanged; order SHALL be strictly FIFO; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 flush SHALL have priority over push, pop and hold: at the next edge count = 0, rf_wdst = 11, and the concurrent push is dropped.
REQ-024 Lookup SHALL be combinational over all valid FIFO entries plus the entry currently presented on rf_* (rf_wdst != 11); the youngest match wins, and the presented entry counts as the oldest.
REQ-025 Entry match rules: mode 00 matches addr1; mode 01 matches addr1 or addr2; mode 10 matches addr1 or address 15.
REQ-026 Within one entry, addr2/data2 SHALL win over addr1/data1 when the addresses are equal, and R15/data15 SHALL win over addr1/data1 when addr1 = 15.
REQ-027 lk_data SHALL be 0 when lk_hit is 0.
REQ-028 full SHALL be (count == DEPTH) and empty SHALL be (count == 0).

Reset
REQ-029 While rst is low, the block SHALL set: FIFO empty, pointers 0, count 0, empty 1, full 0, in_ready 1, rf_wdst 11, rf_add1/rf_add2 0, all rf_wdata 0.
REQ-030 Reset mid-operation SHALL discard all buffered and in-flight requests without issuing them.
REQ-031 Operation SHALL resume on the first clock edge after rst goes high.

Verification
REQ-032 Push mode 00, addr1 = 3, data1 = 16'hABCD into an empty FIFO, hold = 0 -> the next cycle shows rf_wdst = 00, rf_add1 = 3, rf_wdata1 = 16'hABCD; the following cycle shows rf_wdst = 11.
REQ-033 With hold = 1, push 5 requests with DEPTH = 4 -> the 5th stalls (in_ready = 0, full = 1, count = 4); release hold -> 4 issues in order on consecutive cycles, then the 5th issues.
REQ-034 Buffer mode 01 (addr1 = 2, d1 = 16'h1111; addr2 = 2, d2 = 16'h2222), then mode 00 (addr1 = 7, d1 = 16'h0007), with hold = 1 -> lk_addr = 2 gives hit with 16'h2222; lk_addr = 7 gives 16'h0007; lk_addr = 9 gives hit 0, data 0.
REQ-035 Buffer mode 10 (addr1 = 15, d1 = 16'h0001, d15 = 16'h00FF) -> lk_addr = 15 gives 16'h00FF; then push mode 00 to addr1 = 15 with d1 = 16'h0ABC -> lk_addr = 15 gives 16'h0ABC.
REQ-036 With 3 entries buffered, assert flush together with in_valid -> count = 0, rf_wdst = 11, and the pushed request never issues.
REQ-037 Assert rst low while 2 entries are buffered and one is presented on rf_* -> all outputs take the REQ-029 values immediately, with no issue after release.
